// File: rtl/clock_display_driver.sv
// Six-digit HH:MM:SS display driver: converts a packed time snapshot to BCD
// with a serial double-dabble FSM and multiplexes the digits onto a 7-segment bus.
module clock_display_driver #(
    parameter int SCAN_DIV = 1
) (
    input  logic        kh_clk,
    input  logic        reset,
    input  logic [26:0] time_in,
    input  logic        mode_12hr,
    output logic [6:0]  seg,
    output logic [5:0]  an,
    output logic        dp,
    output logic [23:0] bcd_out,
    output logic        upd,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, SHIFT, NEXT} state_t;

    state_t      state, state_nxt;
    logic [2:0]  shift_cnt;
    logic [1:0]  field;
    logic [13:0] dd;
    logic [5:0]  snap_min, snap_sec;
    logic        snap_mode, pm_snap;
    logic        err_hr, err_min, err_sec;
    logic [7:0]  sh_hr, sh_min;
    logic        pm, mode_c;

    logic [4:0]  in_hr;
    logic [5:0]  in_min, in_sec;
    logic [4:0]  hr_pre;
    logic        err_cur;
    logic [7:0]  digits;
    logic        unused_ms;

    assign in_hr     = time_in[26:22];
    assign in_min    = time_in[21:16];
    assign in_sec    = time_in[15:10];
    assign unused_ms = ^time_in[9:0];

    // One double-dabble iteration: add 3 to any BCD nibble >= 5, then shift left.
    function automatic logic [13:0] dd_step(input logic [13:0] v);
        logic [13:0] t;
        t = v;
        if (t[13:10] >= 4'd5) t[13:10] = t[13:10] + 4'd3;
        if (t[9:6]   >= 4'd5) t[9:6]   = t[9:6]   + 4'd3;
        return {t[12:0], 1'b0};
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            4'hF:    glyph = 7'b0111111;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        hr_pre = in_hr;
        if (mode_12hr) begin
            if (in_hr == 5'd0)
                hr_pre = 5'd12;
            else if (in_hr > 5'd12)
                hr_pre = in_hr - 5'd12;
        end
    end

    always_comb begin
        case (field)
            2'd0:    err_cur = err_hr;
            2'd1:    err_cur = err_min;
            default: err_cur = err_sec;
        endcase
        digits = err_cur ? 8'hFF : dd[13:6];
    end

    always_ff @(posedge kh_clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = SHIFT;
            SHIFT:   if (shift_cnt == 3'd5) state_nxt = NEXT;
            NEXT:    state_nxt = (field == 2'd2) ? IDLE : SHIFT;
            default: state_nxt = IDLE;
        endcase
    end

    // Shadow digits only reach bcd_out on the seconds commit, so an aborted pass never shows.
    always_ff @(posedge kh_clk or posedge reset) begin
        if (reset) begin
            shift_cnt <= '0;
            field     <= '0;
            dd        <= '0;
            snap_min  <= '0;
            snap_sec  <= '0;
            snap_mode <= 1'b0;
            pm_snap   <= 1'b0;
            err_hr    <= 1'b0;
            err_min   <= 1'b0;
            err_sec   <= 1'b0;
            sh_hr     <= '0;
            sh_min    <= '0;
            bcd_out   <= '0;
            err       <= 1'b0;
            pm        <= 1'b0;
            mode_c    <= 1'b0;
            upd       <= 1'b0;
        end else begin
            upd <= 1'b0;
            case (state)
                IDLE: begin
                    snap_min  <= in_min;
                    snap_sec  <= in_sec;
                    snap_mode <= mode_12hr;
                    pm_snap   <= mode_12hr && (in_hr >= 5'd12);
                    err_hr    <= (in_hr > 5'd23);
                    err_min   <= (in_min > 6'd59);
                    err_sec   <= (in_sec > 6'd59);
                    dd        <= {9'd0, hr_pre};
                    shift_cnt <= '0;
                    field     <= 2'd0;
                end
                SHIFT: begin
                    dd        <= dd_step(dd);
                    shift_cnt <= shift_cnt + 3'd1;
                end
                NEXT: begin
                    shift_cnt <= '0;
                    case (field)
                        2'd0: begin
                            sh_hr <= digits;
                            dd    <= {8'd0, snap_min};
                            field <= 2'd1;
                        end
                        2'd1: begin
                            sh_min <= digits;
                            dd     <= {8'd0, snap_sec};
                            field  <= 2'd2;
                        end
                        default: begin
                            bcd_out <= {sh_hr, sh_min, digits};
                            err     <= err_hr | err_min | err_sec;
                            pm      <= pm_snap;
                            mode_c  <= snap_mode;
                            upd     <= 1'b1;
                            field   <= 2'd0;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    logic [9:0] presc;
    logic [2:0] idx;
    logic [3:0] cur_digit;
    logic [6:0] seg_nxt;

    always_ff @(posedge kh_clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == 10'(SCAN_DIV - 1)) begin
            presc <= '0;
            idx   <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end else begin
            presc <= presc + 10'd1;
        end
    end

    always_comb begin
        case (idx)
            3'd0:    cur_digit = bcd_out[3:0];
            3'd1:    cur_digit = bcd_out[7:4];
            3'd2:    cur_digit = bcd_out[11:8];
            3'd3:    cur_digit = bcd_out[15:12];
            3'd4:    cur_digit = bcd_out[19:16];
            default: cur_digit = bcd_out[23:20];
        endcase
        // A leading zero in the hours is suppressed only when showing 12-hour time.
        if (mode_c && idx == 3'd5 && cur_digit == 4'd0)
            seg_nxt = 7'b1111111;
        else
            seg_nxt = glyph(cur_digit);
    end

    always_ff @(posedge kh_clk or posedge reset) begin
        if (reset) begin
            seg <= 7'b1000000;
            an  <= 6'b111110;
            dp  <= 1'b1;
        end else begin
            seg <= seg_nxt;
            an  <= ~(6'd1 << idx);
            dp  <= ~(pm && idx == 3'd5);
        end
    end

endmodule

// File: tb/tb_clock_display_driver.sv
// Self-checking bench for clock_display_driver: scoreboard of expected commits,
// display scan checks, scan timing with SCAN_DIV=3, and reset behaviour.
module tb_clock_display_driver;

    logic        kh_clk = 1'b0;
    logic        reset;
    logic [26:0] time_in;
    logic        mode_12hr;

    logic [6:0]  seg, seg3;
    logic [5:0]  an, an3;
    logic        dp, dp3;
    logic [23:0] bcd_out, bcd_out3;
    logic        upd, upd3;
    logic        err, err3;

    clock_display_driver #(.SCAN_DIV(1)) dut (
        .kh_clk(kh_clk), .reset(reset), .time_in(time_in), .mode_12hr(mode_12hr),
        .seg(seg), .an(an), .dp(dp), .bcd_out(bcd_out), .upd(upd), .err(err)
    );

    clock_display_driver #(.SCAN_DIV(3)) dut3 (
        .kh_clk(kh_clk), .reset(reset), .time_in(time_in), .mode_12hr(mode_12hr),
        .seg(seg3), .an(an3), .dp(dp3), .bcd_out(bcd_out3), .upd(upd3), .err(err3)
    );

    always #5 kh_clk = ~kh_clk;

    typedef struct {
        logic [23:0] bcd;
        logic        err;
        logic        pm;
        logic        m12;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   tests_run = 0;
    int   tests_failed = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] two_digits(input int v);
        logic [3:0] t, o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    function automatic exp_t model(input int hr, input int mn, input int sc, input bit m12);
        exp_t e;
        int   hh;
        hh    = hr;
        e.pm  = 1'b0;
        e.m12 = m12;
        if (m12) begin
            e.pm = (hr >= 12);
            if (hr == 0)
                hh = 12;
            else if (hr > 12)
                hh = hr - 12;
        end
        e.bcd = {(hr > 23) ? 8'hFF : two_digits(hh),
                 (mn > 59) ? 8'hFF : two_digits(mn),
                 (sc > 59) ? 8'hFF : two_digits(sc)};
        e.err = (hr > 23) || (mn > 59) || (sc > 59);
        return e;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d, input bit blank_zero);
        if (blank_zero && d == 4'd0)
            return 7'b1111111;
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            4'hF: return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic applyStimulus(input int hr, input int mn, input int sc, input bit m12);
        logic [9:0] ms;
        ms        = 10'($urandom_range(0, 999));
        time_in   = {5'(hr), 6'(mn), 6'(sc), ms};
        mode_12hr = m12;
        exp_q.push_back(model(hr, mn, sc, m12));
    endtask

    task automatic waitUpd();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge kh_clk);
            if (upd) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("upd_seen", 32'(seen), 32'd1);
    endtask

    task automatic popCompare(input string tag);
        cur = exp_q.pop_front();
        checkOutput({tag, "_bcd"}, 32'(bcd_out), 32'(cur.bcd));
        checkOutput({tag, "_err"}, 32'(err), 32'(cur.err));
    endtask

    // The second commit after a change is guaranteed to reflect it.
    task automatic compareCommit(input string tag);
        waitUpd();
        waitUpd();
        popCompare(tag);
    endtask

    task automatic checkDisplay(input string tag);
        int         p, zeros;
        logic [3:0] d;
        for (int n = 0; n < 6; n++) begin
            @(posedge kh_clk);
            #1;
            p = 0;
            zeros = 0;
            for (int b = 0; b < 6; b++) begin
                if (an[b] == 1'b0) begin
                    p = b;
                    zeros++;
                end
            end
            checkOutput({tag, "_an_onehot"}, 32'(zeros), 32'd1);
            d = cur.bcd[p*4 +: 4];
            checkOutput({tag, "_seg"}, 32'(seg), 32'(glyph(d, cur.m12 && p == 5)));
            checkOutput({tag, "_dp"}, 32'(dp), 32'(!(p == 5 && cur.pm)));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         first;
        logic [5:0] exp_an;

        reset     = 1'b1;
        time_in   = '0;
        mode_12hr = 1'b0;
        repeat (3) @(negedge kh_clk);

        checkOutput("reset_an", 32'(an), 32'(6'b111110));
        checkOutput("reset_seg", 32'(seg), 32'(7'b1000000));
        checkOutput("reset_dp", 32'(dp), 32'd1);
        checkOutput("reset_bcd", 32'(bcd_out), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        checkOutput("reset_upd", 32'(upd), 32'd0);
        checkOutput("reset_an3", 32'(an3), 32'(6'b111110));

        applyStimulus(13, 5, 9, 1'b1);
        reset = 1'b0;

        // First commit timing and the SCAN_DIV=3 walk share the same edges.
        first = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge kh_clk);
            #1;
            if (k <= 19) begin
                exp_an = ~(6'd1 << (((k - 1) / 3) % 6));
                checkOutput("scan3_an", 32'(an3), 32'(exp_an));
            end
            if (upd && first == 0)
                first = k;
            if (k >= 19 && first != 0)
                break;
        end
        checkOutput("first_upd_edge", 32'(first), 32'd22);
        popCompare("pm_0105");
        checkDisplay("pm_0105");

        applyStimulus(13, 5, 9, 1'b0);
        compareCommit("h24_1305");
        checkDisplay("h24_1305");

        applyStimulus(0, 59, 59, 1'b1);
        compareCommit("midnight12");
        checkDisplay("midnight12");

        applyStimulus(0, 59, 59, 1'b0);
        compareCommit("midnight24");
        checkDisplay("midnight24");

        applyStimulus(13, 60, 9, 1'b0);
        compareCommit("min_err");
        checkDisplay("min_err");

        applyStimulus(24, 30, 60, 1'b0);
        compareCommit("hr_sec_err");
        checkDisplay("hr_sec_err");

        applyStimulus(23, 0, 0, 1'b1);
        compareCommit("pm_1100");
        checkDisplay("pm_1100");

        applyStimulus(12, 34, 56, 1'b1);
        compareCommit("noon12");
        checkDisplay("noon12");

        // Inputs changed mid-conversion must not disturb the snapshot in flight.
        waitUpd();
        applyStimulus(9, 8, 7, 1'b1);
        repeat (3) @(negedge kh_clk);
        applyStimulus(21, 22, 23, 1'b0);
        waitUpd();
        popCompare("snapshot_hold");
        waitUpd();
        popCompare("snapshot_next");

        waitUpd();
        repeat (10) @(negedge kh_clk);
        reset = 1'b1;
        #1;
        checkOutput("midreset_bcd", 32'(bcd_out), 32'd0);
        checkOutput("midreset_err", 32'(err), 32'd0);
        checkOutput("midreset_upd", 32'(upd), 32'd0);
        checkOutput("midreset_an", 32'(an), 32'(6'b111110));
        checkOutput("midreset_seg", 32'(seg), 32'(7'b1000000));
        checkOutput("midreset_dp", 32'(dp), 32'd1);
        repeat (2) @(negedge kh_clk);
        applyStimulus(21, 22, 23, 1'b0);
        reset = 1'b0;
        first = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge kh_clk);
            #1;
            if (upd) begin
                first = k;
                break;
            end
        end
        checkOutput("rerelease_upd_edge", 32'(first), 32'd22);
        popCompare("rerelease");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/clock_display_driver.md
CLOCK_DISPLAY_DRIVER -- requirements
Module: clock_display_driver

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 1, number of kh_clk cycles each digit stays selected (legal range 1..1023).
REQ-002 SHALL provide port kh_clk  input  1  clock (1 kHz system tick).
REQ-003 SHALL provide port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port time_in  input  27  packed time {hr[4:0], min[5:0], sec[5:0], ms[9:0]}; ms is ignored.
REQ-005 SHALL provide port mode_12hr  input  1  1 = 12-hour rendering, 0 = 24-hour rendering.
REQ-006 SHALL provide port seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-007 SHALL provide port an  output  6  digit enables, active-low, one-hot; an[0] = seconds ones, an[5] = hours tens.
REQ-008 SHALL provide port dp  output  1  decimal point, active-low; lit on digit 5 as PM indicator.
REQ-009 SHALL provide port bcd_out  output  24  committed digits {hT,hO,mT,mO,sT,sO}, 4 bits each.
REQ-010 SHALL provide port upd  output  1  one-cycle pulse on each commit of bcd_out.
REQ-011 SHALL provide port err  output  1  range-error flag of the last committed conversion.

Function
REQ-012 Conversion FSM states SHALL be IDLE, SHIFT, NEXT; free-running, restarting in IDLE after every commit.
REQ-013 IDLE (1 cycle) SHALL snapshot time_in and mode_12hr; later input changes SHALL NOT affect the conversion in progress.
REQ-014 Fields SHALL be converted in order hr, min, sec, each by 6-cycle shift-add-3 (double dabble) in SHIFT, followed by 1 cycle in NEXT storing that field's two digits to a shadow register.
REQ-015 Conversion period SHALL be exactly 22 cycles (1 + 3x7); upd SHALL pulse and bcd_out/err SHALL update atomically in the NEXT cycle of the sec field.
REQ-016 Latency: a stable time_in SHALL appear on bcd_out no later than 44 cycles after it is applied.
REQ-017 Hour preprocessing in 12-hour mode: hr 0 -> 12, hr 13..23 -> hr-12, hr 1..12 unchanged; PM = (hr >= 12).
REQ-018 In 24-hour mode the hour SHALL be converted unchanged and PM SHALL be 0.
REQ-019 Range error: hr > 23, min > 59 or sec > 59 SHALL set err = 1 and force the offending field's two digits to code 4'hF.
REQ-020 Digit code 4'hF SHALL render as dash (seg = 7'b0111111); codes 0..9 render standard glyphs (0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000).
REQ-021 Hours tens digit equal to 0 SHALL render blank (seg = 7'b1111111) in 12-hour mode only.
REQ-022 Scan: a prescaler SHALL count 0..SCAN_DIV-1; on terminal count the digit index SHALL advance, wrapping 5 -> 0.
REQ-023 seg, an, dp SHALL be registered from the current digit index and committed bcd_out, one cycle after the index changes.
REQ-024 dp SHALL be 0 only when the index is 5 and the committed PM flag is 1; otherwise 1.
REQ-025 Digit values 10..14 SHALL NOT occur; if they did, they SHALL render blank.

Reset
REQ-026 On reset assertion, immediately: FSM = IDLE, prescaler = 0, digit index = 0, bcd_out = 0, PM = 0, err = 0, upd = 0.
REQ-027 Reset outputs SHALL be an = 6'b111110, seg = 7'b1000000, dp = 1.
REQ-028 Reset mid-conversion SHALL discard shadow digits; no upd SHALL issue for the aborted conversion.
REQ-029 First upd after reset release SHALL occur on the 22nd rising kh_clk edge.

Verification
REQ-030 time_in hr=13, min=5, sec=9, mode_12hr=1, held 44 cycles -> bcd_out = 24'h010509, hours tens blank, dp low on an[5], err=0.
REQ-031 Same time, mode_12hr=0 -> bcd_out = 24'h130509, dp high on every digit.
REQ-032 hr=0, min=59, sec=59, mode_12hr=1 -> bcd_out = 24'h125959; mode_12hr=0 -> 24'h005959 with hours tens showing 0.
REQ-033 min=60 -> err=1, bcd_out[15:8] = 8'hFF, minute digits show dashes; other fields correct.
REQ-034 SCAN_DIV=3, 18 cycles -> an walks 111110..011111, each value held exactly 3 cycles, then wraps to 111110.
REQ-035 Reset asserted at cycle 10 of a conversion -> outputs at reset values at once, no upd until 22 edges after release.
